// File: rtl/alu_seq.sv
// alu_seq: operand/ALU stage feeding the accumulator.
// Single-cycle logic/arithmetic ops complete on the edge that samples start.
// MUL runs a WIDTH-step shift-add sequence with a busy/done handshake so the
// CPU control can stall. result/c_out are registered and only change on a
// completion edge or reset.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out
);

   // Product width and iteration counter sizing
   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // Operation encodings
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Single-cycle ops. Returns {flag, value}; the flag is the carry for ADD
   // and the borrow for SUB (bit WIDTH of the widened difference is set
   // exactly when b > a). MUL is handled by the sequencer, not here.
   function automatic logic [WIDTH:0] alu_eval(
      input logic [2:0]       f_op,
      input logic [WIDTH-1:0] f_a,
      input logic [WIDTH-1:0] f_b
   );
      logic [WIDTH:0] r;
      r = {(WIDTH+1){1'b0}};
      case (f_op)
         OP_PASS: r = {1'b0, f_b};
         OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
         OP_SUB:  r = {1'b0, f_a} - {1'b0, f_b};
         OP_AND:  r = {1'b0, f_a & f_b};
         OP_OR:   r = {1'b0, f_a | f_b};
         OP_XOR:  r = {1'b0, f_a ^ f_b};
         OP_NOP:  r = {1'b0, f_a};
         default: r = {(WIDTH+1){1'b0}};
      endcase
      return r;
   endfunction

   // Flops
   state_t           state_q,  state_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_out_q,  c_out_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [PW-1:0]    mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    prod_q,   prod_d;

   // Combinational helpers
   logic [PW-1:0]    prod_step_s;
   logic [WIDTH:0]   alu_s;

   // Partial product after this cycle's conditional add of the multiplicand
   always_comb begin
      if (mplier_q[0]) begin
         prod_step_s = prod_q + mcand_q;
      end else begin
         prod_step_s = prod_q;
      end
   end

   // Single-cycle result for the op presented with start
   always_comb begin
      alu_s = alu_eval(op, a, b);
   end

   // Next-state, sequencer and completion logic
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      c_out_d  = c_out_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  // Operands are frozen here; later changes on a/b are ignored.
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  prod_d   = {PW{1'b0}};
                  count_d  = CNT_ZERO;
                  busy_d   = 1'b1;
                  state_d  = ST_MUL;
               end else begin
                  result_d = alu_s[WIDTH-1:0];
                  c_out_d  = alu_s[WIDTH];
                  done_d   = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_MUL: begin
            // start is deliberately not looked at while a MUL runs.
            prod_d   = prod_step_s;
            mcand_d  = {mcand_q[PW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            if (count_q == CNT_LAST) begin
               result_d = prod_step_s[WIDTH-1:0];
               c_out_d  = |prod_step_s[PW-1:WIDTH];
               done_d   = 1'b1;
               busy_d   = 1'b0;
               count_d  = CNT_ZERO;
               state_d  = ST_IDLE;
            end else begin
               count_d  = count_q + CNT_ONE;
               state_d  = ST_MUL;
            end
         end

         default: begin
            busy_d  = 1'b0;
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any MUL in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= {WIDTH{1'b0}};
         c_out_q  <= 1'b0;
         count_q  <= CNT_ZERO;
         mcand_q  <= {PW{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         prod_q   <= {PW{1'b0}};
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign c_out  = c_out_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, c_out;
   logic [W-1:0] result;

   int n_checks = 0;
   int n_fails  = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .c_out(c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int s;
      case (o)
         3'd0: return {1'b0, y};
         3'd1: begin
            s = int'(x) + int'(y);
            return {(s >= (1 << W)), W'(s)};
         end
         3'd2: return {(y > x), W'(x - y)};
         3'd3: return {1'b0, x & y};
         3'd4: return {1'b0, x | y};
         3'd5: return {1'b0, x ^ y};
         3'd7: return {1'b0, x};
         default: return '0;
      endcase
   endfunction

   logic           m_busy, m_done, m_cout;
   logic [W-1:0]   m_result;
   logic [2*W-1:0] mul_prod;
   int             mul_left;   // edges until the running MUL completes

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_cout   <= 1'b0;
         m_result <= '0;
         mul_prod <= '0;
         mul_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (mul_left > 0) begin
            if (mul_left == 1) begin
               m_result <= mul_prod[W-1:0];
               m_cout   <= |mul_prod[2*W-1:W];
               m_done   <= 1'b1;
               m_busy   <= 1'b0;
            end
            mul_left <= mul_left - 1;
         end else if (start) begin
            if (op == 3'd6) begin
               mul_prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
               mul_left <= W;
               m_busy   <= 1'b1;
            end else begin
               {m_cout, m_result} <= ref_op(op, a, b);
               m_done <= 1'b1;
            end
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("busy",   {31'd0, busy},  {31'd0, m_busy});
      chk("done",   {31'd0, done},  {31'd0, m_done});
      chk("result", {24'd0, result}, {24'd0, m_result});
      chk("c_out",  {31'd0, c_out}, {31'd0, m_cout});
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk_out(input string name, input logic d, input logic [W-1:0] r, input logic c);
      chk({name, "_done"},   {31'd0, done},   {31'd0, d});
      chk({name, "_result"}, {24'd0, result}, {24'd0, r});
      chk({name, "_cout"},   {31'd0, c_out},  {31'd0, c});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int pulses;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk_out("reset", 1'b0, 8'h00, 1'b0);
      #2 rst = 1'b0;
      @(negedge clk);

      // Single-cycle ops
      issue(3'd1, 8'h05, 8'h0F);
      chk_out("add1", 1'b1, 8'h14, 1'b0);
      @(negedge clk);
      chk_out("add1_hold", 1'b0, 8'h14, 1'b0);
      issue(3'd1, 8'hFF, 8'h01);
      chk_out("add_carry", 1'b1, 8'h00, 1'b1);
      issue(3'd2, 8'h03, 8'h05);
      chk_out("sub_borrow", 1'b1, 8'hFE, 1'b1);
      issue(3'd2, 8'h05, 8'h03);
      chk_out("sub", 1'b1, 8'h02, 1'b0);

      // MUL latency, busy window and operand freeze
      issue(3'd6, 8'h0D, 8'h0B);
      chk("mul_busy0", {31'd0, busy}, 32'd1);
      a = 8'hFF; b = 8'hFF;
      for (int i = 1; i < W; i++) begin
         @(negedge clk);
         chk("mul_busy", {31'd0, busy}, 32'd1);
         chk("mul_nodone", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      chk("mul_busy_end", {31'd0, busy}, 32'd0);
      chk_out("mul1", 1'b1, 8'h8F, 1'b0);

      // MUL overflow, then back-to-back AND in the done cycle
      issue(3'd6, 8'h10, 8'h20);
      wait_done(cyc);
      chk("mul2_latency", cyc, 32'd8);
      chk_out("mul2", 1'b1, 8'h00, 1'b1);
      issue(3'd3, 8'hF0, 8'h3C);
      chk_out("and_b2b", 1'b1, 8'h30, 1'b0);

      // start during MUL is ignored
      issue(3'd6, 8'h07, 8'h09);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 8'h01; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            chk("mul3_result", {24'd0, result}, 32'h3F);
         end
      end
      chk("mul3_pulses", pulses, 32'd1);

      // Reset mid-MUL
      issue(3'd6, 8'h0F, 8'h0F);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk_out("rst_mid", 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      issue(3'd1, 8'h01, 8'h01);
      chk_out("add_after_rst", 1'b1, 8'h02, 1'b0);

      // Randomized traffic, checked by the per-cycle compare
      repeat (400) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         op    = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) op = 3'd6;
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Operand/ALU stage directly upstream of the accumulator in the one-cycle CPU datapath.
- Takes the accumulator's current value (operand a) and an instruction operand (operand b), then computes a result.
- Its one-cycle `done` strobe drives the accumulator's `en`, and `result` drives the accumulator's `in`.
- Logic ops complete in one cycle. MUL is a WIDTH-cycle shift-add sequence with a busy/done handshake so the CPU control can stall.

Parameters:
- WIDTH, 8, datapath width of a, b and result; must match the accumulator WIDTH, minimum 2.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request; sampled on rising clk edge when state is IDLE
- op     input   3      operation select, sampled with start
- a      input   WIDTH  operand A (accumulator output), sampled with start
- b      input   WIDTH  operand B, sampled with start
- busy   output  1      high while a MUL is in progress
- done   output  1      one-cycle pulse; result/c_out valid; connects to accumulator en
- result output  WIDTH  registered result, held until the next completion
- c_out  output  1      registered carry/borrow/overflow flag, held with result

Behaviour:
- Reset (async, immediate) gives: state=IDLE, busy=0, done=0, result=0, c_out=0, iteration counter=0, operand registers=0.
- Reset asserted mid-MUL aborts the operation. No done pulse is produced, and after release the block accepts start on the first edge.
- FSM states are IDLE and MUL.
  - IDLE with start=1 and op!=110: on that edge, result/c_out are written, done=1, and state stays IDLE. Latency is 1 edge.
  - IDLE with start=1 and op=110: on that edge, a, b and op are captured, the partial product is cleared, count=0, busy=1, and state goes to MUL.
  - MUL: each edge performs one step. If the multiplier LSB is 1, add the multiplicand into a 2*WIDTH partial product. Then shift the multiplicand left, shift the multiplier right, and increment count.
  - On the edge where count==WIDTH-1 (the WIDTH-th step): result=product[WIDTH-1:0], c_out=|product[2*WIDTH-1:WIDTH], done=1, busy=0, state goes to IDLE.
  - MUL latency: start at edge N gives done high after edge N+WIDTH.
- done is high for exactly one cycle, and is 0 on every edge that does not complete an operation.
- start while busy=1 is ignored entirely: no capture and no effect on the running MUL.
- start in the cycle where done=1 (state IDLE) is accepted normally, giving back-to-back operations.
- Operands are used only as sampled at start. Changes on a/b during MUL (for example, the accumulator updating) do not affect the result.
- Ops (WIDTH-bit modular arithmetic):
  - 000 PASS: result=b, c_out=0
  - 001 ADD: result=a+b, c_out=carry out of the MSB
  - 010 SUB: result=a-b, c_out=1 when b>a (borrow)
  - 011 AND: c_out=0
  - 100 OR: c_out=0
  - 101 XOR: c_out=0
  - 110 MUL: low half of the product, c_out=1 if the high half is nonzero
  - 111 NOP: result=a, c_out=0, done still pulses
- result and c_out change only on completion edges or reset. They are never combinational from the inputs.

Test Plan (WIDTH=8):
- ADD a=0x05 b=0x0F start one cycle -> after the next edge done=1, result=0x14, c_out=0. done=0 the following cycle and result holds at 0x14.
- ADD a=0xFF b=0x01 -> result=0x00, c_out=1. SUB a=0x03 b=0x05 -> result=0xFE, c_out=1. SUB a=0x05 b=0x03 -> result=0x02, c_out=0.
- MUL a=0x0D b=0x0B, start at edge N -> busy=1 for edges N..N+7, done=1 only after edge N+8, result=0x8F, c_out=0. Change a/b to 0xFF during MUL -> result unchanged.
- MUL a=0x10 b=0x20 -> result=0x00, c_out=1. Immediately start AND a=0xF0 b=0x3C in the done cycle -> one edge later done=1, result=0x30.
- MUL in progress, pulse start with op=001 at edge N+3 -> ignored, MUL completes normally with a single done pulse.
- MUL in progress, assert rst between edges N+4 and N+5 -> busy, done, result and c_out go to 0 immediately with no done pulse. After release, ADD 0x01+0x01 -> result=0x02 in 1 cycle.
